game_input_processor: RTL
=========================

// Module: game_input_processor
// PURPOSE
//  Parametrised multi-player input front-end in the clk_60Hz_game domain. Takes active-low
//  key vectors from the button_debouncer instances, syncs and inverts them, and produces per-key
//  level, press/release pulses, auto-repeat pulses and a frame-aged press buffer with ack
//  handshake. Feeds the game FSM (menus, movement, attack) for all players.
// PARAMETERS
//  NUM_PLAYERS   2       players; key vectors flattened as index p*NUM_KEYS+k
//  NUM_KEYS      4       keys per player (order from game_input_pkg)
//  SYNC_STAGES   2       synchroniser flops per key, >=1
//  REPEAT_DELAY  20      frames held before first repeat pulse, >=1
//  REPEAT_RATE   6       frames between subsequent repeats; 0 disables repeat
//  BUF_FRAMES    8       frames a buffered press stays valid without ack, >=1
//  BUF_MASK      4'b1100 per-key-slot enable of press buffer (bit k applies to key k of every player)
// PORTS (N = NUM_PLAYERS*NUM_KEYS)
//  clk_60Hz_game      in   1  game clock
//  reset              in   1  async, active-high
//  enable             in   1  1 = normal; 0 = freeze command generation
//  keys_n_in          in   N  debounced keys, active-low
//  level_out          out  N  synced key level, active-high
//  press_pulse_out    out  N  1-cycle pulse on press
//  release_pulse_out  out  N  1-cycle pulse on release
//  repeat_pulse_out   out  N  1-cycle auto-repeat pulse while held
//  buf_valid_out      out  N  buffered press pending (0 on slots with BUF_MASK bit clear)
//  buf_ack_in         in   N  consumer ack, per key
// BEHAVIOUR
//  - Reset: every flop, counter and output -> 0, immediately (async); reset mid-hold or
//    mid-buffer discards state; key still held after reset yields a fresh press pulse.
//  - All outputs registered. s[i] = sync chain of ~keys_n_in; level_out = s[last].
//  - Latency: input change -> level_out after SYNC_STAGES edges. press_pulse_out = 1 on the
//    same cycle level_out first goes 1 (computed from s[last-1] & ~s[last]); release symmetric.
//  - Per-key hold counter, width $clog2(REPEAT_DELAY+1), saturating: cleared while level low.
//    Press pulse at cycle t0 -> repeat pulses at t0+REPEAT_DELAY, then every REPEAT_RATE
//    frames until release. REPEAT_RATE=0: no repeats. Release on a repeat cycle: no pulse.
//  - Buffer (BUF_MASK slots only): buf_valid rises with press pulse (same edge), age reset to 0.
//    Cleared at next edge if buf_ack_in=1 while valid, or after valid for BUF_FRAMES cycles.
//    Ack while not valid: ignored. New press with simultaneous ack: press wins, valid stays,
//    age restarts. Release does not clear buffer.
//  - enable=0: sync chain and level_out keep tracking; press/release/repeat pulses forced 0;
//    hold counters and buffers cleared. Key held across enable 0->1 gives no press pulse
//    and restarts repeat timing from the enable edge as if t0 = that cycle.
//  - Players and keys fully independent; simultaneous events on different keys never interact.
// STRUCTURE
//  - game_input_pkg: KEY_LEFT=0, KEY_RIGHT=1, KEY_ATTACK=2, KEY_CONFIRM=3, NUM_KEYS,
//    default REPEAT_DELAY/REPEAT_RATE/BUF_FRAMES constants, flat-index helper function.
//  - Sub-module input_key_channel: one key (sync, edge detect, repeat counter, optional buffer
//    via parameter BUF_EN); top is a generate loop over N plus enable fan-out.
// TESTING (defaults)
//  1 Reset with keys_n_in=0 (all held), release reset -> level_out=all 1 after 2 edges,
//    press_pulse_out=all 1 for exactly that one cycle, no other pulses.
//  2 P1 left (bit 0) held 40 frames -> press at t0, repeats at t0+20, t0+26, t0+32, t0+38,
//    release pulse 40 cycles after t0; bit 4 (P2 left) stays 0 throughout.
//  3 P2 attack (bit 6) tapped 3 frames, no ack -> buf_valid_out[6]=1 for exactly 8 cycles
//    from t0; bit 2 never asserts; P1 left (bit 0, mask clear) buf_valid stays 0.
//  4 Confirm (bit 3) pressed, ack at t0+3 -> valid low from t0+4; second press coincident
//    with ack -> valid stays 1, times out 8 cycles after the new press.
//  5 enable=0 while right held for 30 frames, then enable=1 -> no pulses while disabled,
//    buffers 0, no press pulse on re-enable, first repeat 20 cycles after enable edge.
//  6 Assert reset at t0+10 during hold and pending buffer -> all outputs 0 asynchronously;
//    after release, held key produces new press pulse at SYNC_STAGES edges.

Source files
------------

// File: rtl/game_input_pkg.sv
// Shared constants for the game input front-end: key slot order, default
// timing in frames, and the flat player/key index used on every key vector.
package game_input_pkg;

  // Key slot order inside one player's group of the flat vectors.
  typedef enum logic [1:0] {
    KEY_LEFT    = 2'd0,
    KEY_RIGHT   = 2'd1,
    KEY_ATTACK  = 2'd2,
    KEY_CONFIRM = 2'd3
  } key_e;

  localparam int NUM_KEYS = 4;

  // Default timing, all counted in 60 Hz frames.
  localparam int DEFAULT_SYNC_STAGES  = 2;
  localparam int DEFAULT_REPEAT_DELAY = 20;
  localparam int DEFAULT_REPEAT_RATE  = 6;
  localparam int DEFAULT_BUF_FRAMES   = 8;

  // Attack and confirm are buffered by default; movement keys are not.
  localparam logic [NUM_KEYS-1:0] DEFAULT_BUF_MASK = 4'b1100;

  // Position of key k of player p in a flattened key vector.
  function automatic int flat_idx(input int p, input int k, input int keys_per_player);
    return p * keys_per_player + k;
  endfunction

endpackage

// File: rtl/input_key_channel.sv
// One key of one player: input synchroniser, press/release edge pulses,
// hold counter driving auto-repeat, and an optional frame-aged press buffer.
//
// Buffer handshake: buf_valid rises on the edge that produces the press pulse
// and stays high until the consumer holds buf_ack high at a clock edge while
// buf_valid is high, or until it has been high for BUF_FRAMES cycles. Ack while
// buf_valid is low is ignored. A new press on the same edge as an ack wins:
// buf_valid stays high and the age restarts.
module input_key_channel
  import game_input_pkg::*;
#(
  parameter int SYNC_STAGES  = DEFAULT_SYNC_STAGES,
  parameter int REPEAT_DELAY = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEFAULT_REPEAT_RATE,
  parameter int BUF_FRAMES   = DEFAULT_BUF_FRAMES,
  parameter bit BUF_EN       = 1'b1
) (
  input  logic clk_60Hz_game,
  input  logic reset,
  input  logic enable,
  input  logic key_n,
  input  logic buf_ack,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic buf_valid
);

  localparam int HOLD_W = $clog2(REPEAT_DELAY + 1);
  localparam int RATE_W = (REPEAT_RATE < 1) ? 1 : $clog2(REPEAT_RATE + 1);
  localparam int AGE_W  = (BUF_FRAMES < 2) ? 1 : $clog2(BUF_FRAMES);

  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(REPEAT_DELAY);
  localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [RATE_W-1:0] RATE_LAST = RATE_W'(REPEAT_RATE - 1);
  localparam logic [AGE_W-1:0]  AGE_LAST  = AGE_W'(BUF_FRAMES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   repeat_q, repeat_d;
  logic                   run_q, run_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [RATE_W-1:0]      rate_q, rate_d;
  logic                   buf_valid_q, buf_valid_d;
  logic [AGE_W-1:0]       age_q, age_d;

  // The last sync stage is the visible level; its next value is what the
  // edge detector compares against, so pulses line up with level changes.
  assign level_q = sync_q[SYNC_STAGES-1];
  assign level_d = sync_d[SYNC_STAGES-1];

  // Next-state for sync chain, edge pulses, hold/repeat counters and buffer.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = ~key_n;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end

    press_d   = enable & level_d & ~level_q;
    release_d = enable & ~level_d & level_q;

    // run marks cycles where the key is held and commands are enabled; a
    // 0->1 step of run (press or re-enable while held) is repeat time zero.
    run_d    = enable & level_d;
    hold_d   = '0;
    rate_d   = '0;
    repeat_d = 1'b0;
    if (run_d && run_q) begin
      if (hold_q == HOLD_MAX) begin
        hold_d = hold_q;
        if (REPEAT_RATE != 0) begin
          if (rate_q == RATE_LAST) begin
            repeat_d = 1'b1;
          end else begin
            rate_d = rate_q + 1'b1;
          end
        end
      end else begin
        hold_d = hold_q + 1'b1;
        if ((hold_q == HOLD_PRE) && (REPEAT_RATE != 0)) begin
          repeat_d = 1'b1;
        end
      end
    end

    buf_valid_d = 1'b0;
    age_d       = '0;
    if (BUF_EN && enable) begin
      if (press_d) begin
        buf_valid_d = 1'b1;
      end else if (buf_valid_q && !buf_ack && (age_q != AGE_LAST)) begin
        buf_valid_d = 1'b1;
        age_d       = age_q + 1'b1;
      end
    end
  end

  // State registers; async reset discards any hold or pending buffer.
  always_ff @(posedge clk_60Hz_game or posedge reset) begin
    if (reset) begin
      sync_q      <= '0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      repeat_q    <= 1'b0;
      run_q       <= 1'b0;
      hold_q      <= '0;
      rate_q      <= '0;
      buf_valid_q <= 1'b0;
      age_q       <= '0;
    end else begin
      sync_q      <= sync_d;
      press_q     <= press_d;
      release_q   <= release_d;
      repeat_q    <= repeat_d;
      run_q       <= run_d;
      hold_q      <= hold_d;
      rate_q      <= rate_d;
      buf_valid_q <= buf_valid_d;
      age_q       <= age_d;
    end
  end

  assign level         = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign repeat_pulse  = repeat_q;
  assign buf_valid     = buf_valid_q;

endmodule

// File: rtl/game_input_processor.sv
// Multi-player input front-end: one input_key_channel per key of every
// player, all sharing the enable and the game clock. Buffering is enabled per
// key slot by BUF_MASK, identically for every player.
module game_input_processor #(
  parameter int                     NUM_PLAYERS  = 2,
  parameter int                     NUM_KEYS     = game_input_pkg::NUM_KEYS,
  parameter int                     SYNC_STAGES  = game_input_pkg::DEFAULT_SYNC_STAGES,
  parameter int                     REPEAT_DELAY = game_input_pkg::DEFAULT_REPEAT_DELAY,
  parameter int                     REPEAT_RATE  = game_input_pkg::DEFAULT_REPEAT_RATE,
  parameter int                     BUF_FRAMES   = game_input_pkg::DEFAULT_BUF_FRAMES,
  parameter logic [NUM_KEYS-1:0]    BUF_MASK     = game_input_pkg::DEFAULT_BUF_MASK
) (
  input  logic                            clk_60Hz_game,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [NUM_PLAYERS*NUM_KEYS-1:0] keys_n_in,
  output logic [NUM_PLAYERS*NUM_KEYS-1:0] level_out,
  output logic [NUM_PLAYERS*NUM_KEYS-1:0] press_pulse_out,
  output logic [NUM_PLAYERS*NUM_KEYS-1:0] release_pulse_out,
  output logic [NUM_PLAYERS*NUM_KEYS-1:0] repeat_pulse_out,
  output logic [NUM_PLAYERS*NUM_KEYS-1:0] buf_valid_out,
  input  logic [NUM_PLAYERS*NUM_KEYS-1:0] buf_ack_in
);

  import game_input_pkg::*;

  // One independent channel per (player, key) slot.
  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      localparam int IDX = flat_idx(p, k, NUM_KEYS);

      input_key_channel #(
        .SYNC_STAGES  (SYNC_STAGES),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE),
        .BUF_FRAMES   (BUF_FRAMES),
        .BUF_EN       (BUF_MASK[k])
      ) u_channel (
        .clk_60Hz_game (clk_60Hz_game),
        .reset         (reset),
        .enable        (enable),
        .key_n         (keys_n_in[IDX]),
        .buf_ack       (buf_ack_in[IDX]),
        .level         (level_out[IDX]),
        .press_pulse   (press_pulse_out[IDX]),
        .release_pulse (release_pulse_out[IDX]),
        .repeat_pulse  (repeat_pulse_out[IDX]),
        .buf_valid     (buf_valid_out[IDX])
      );
    end
  end

endmodule
